// File: rtl/ss2_pkg.sv
// Shared types and constants for the save-state bus initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, device header layout, error codes, bus gap length.
package ss2_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_QUERY,
        S_HDR,
        S_DEV,
        S_MEM,
        S_NEXTENT,
        S_NEXT,
        S_GAP,
        S_DONE,
        S_ERR
    } state_e;

    // Device header word layout
    localparam int HDR_TAG_HI   = 63;
    localparam int HDR_TAG_LO   = 56;
    localparam int HDR_WIDTH_HI = 33;
    localparam int HDR_WIDTH_LO = 32;
    localparam int HDR_COUNT_HI = 31;
    localparam int HDR_COUNT_LO = 0;

    typedef struct packed {
        logic [HDR_TAG_HI-HDR_TAG_LO:0]     tag;
        logic [HDR_TAG_LO-HDR_WIDTH_HI-2:0] rsvd;
        logic [HDR_WIDTH_HI-HDR_WIDTH_LO:0] width;
        logic [HDR_COUNT_HI:HDR_COUNT_LO]   count;
    } hdr_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DEV_TMO = 2'd1;
    localparam logic [1:0] ERR_HDR     = 2'd2;
    localparam logic [1:0] ERR_MEM_TMO = 2'd3;

    // Idle cycles after every bus transaction so a device's stale re-ack drains
    localparam int GAP_CYCLES = 1;

endpackage

// File: rtl/ss2_if.sv
// Save-state device bus and buffer-memory port bundles.
// Latency: n/a (wiring only).
// Backpressure: device side via ss_ack, memory side via mem_req/mem_ack.
// ss2_bus_if: strobes, select, address, data out; per-device data/ack back.
// ss2_mem_if: word address, write data, we, req out; ack and read data back.
interface ss2_bus_if #(parameter int COUNT = 8);
    logic [63:0]             ss_data;
    logic [23:0]             ss_addr;
    logic [COUNT-1:0]        ss_select;
    logic                    ss_write;
    logic                    ss_read;
    logic                    ss_query;
    logic [COUNT-1:0][63:0]  ss_data_in;
    logic [COUNT-1:0]        ss_ack;

    modport master (output ss_data, ss_addr, ss_select, ss_write, ss_read, ss_query,
                    input  ss_data_in, ss_ack);
    modport slave  (input  ss_data, ss_addr, ss_select, ss_write, ss_read, ss_query,
                    output ss_data_in, ss_ack);
endinterface

interface ss2_mem_if #(parameter int MEMAW = 24);
    logic [MEMAW-1:0] mem_addr;
    logic [63:0]      mem_wdata;
    logic             mem_we;
    logic             mem_req;
    logic             mem_ack;
    logic [63:0]      mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_we, mem_req,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_addr, mem_wdata, mem_we, mem_req,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/ss2_watchdog.sv
// Loadable down-counter flagging a stalled bus or memory transaction.
// Latency: expired_o asserts TIMEOUT cycles after the load cycle.
// Backpressure: none; counts while en_i is high, holds at zero.
// Ports: clock, reset_n, load_i (restart at TIMEOUT), en_i, expired_o.
module ss2_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [WW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = WW'(TIMEOUT);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - WW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ss2_master.sv
// Save-state bus initiator: walks every device, copying its entries to or from buffer memory.
// Latency: per entry ~2 cycles device ack + GAP + memory ack; done pulses one cycle after the last device.
// Backpressure: strobes and mem_req held until acked; a watchdog aborts stalled transactions.
// Ports: clock/reset_n; start/restore/base_addr in; busy/done/error/err_code/words out;
//        ss (device bus master modport); mem (buffer memory master modport).
module ss2_master
    import ss2_pkg::*;
#(
    parameter int COUNT   = 8,
    parameter int TIMEOUT = 255,
    parameter int MEMAW   = 24
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             restore,
    input  logic [MEMAW-1:0] base_addr,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [MEMAW-1:0] words,
    ss2_bus_if.master        ss,
    ss2_mem_if.master        mem
);
    localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;

    state_e           state_q, state_d, ret_q, ret_d;
    logic [1:0]       gap_q, gap_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [31:0]      entry_q, entry_d, cnt_q, cnt_d;
    hdr_t             hdr_q, hdr_d;
    logic [63:0]      dat_q, dat_d;
    logic [MEMAW-1:0] ptr_q, ptr_d, words_q, words_d;
    logic             mode_q, mode_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [63:0]      ss_data_q, ss_data_d;
    logic [23:0]      ss_addr_q, ss_addr_d;
    logic [COUNT-1:0] ss_select_q, ss_select_d;
    logic             ss_write_q, ss_write_d, ss_read_q, ss_read_d, ss_query_q, ss_query_d;
    logic [63:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_we_q, mem_we_d, mem_req_q, mem_req_d;
    logic             wd_load, wd_expired;

    // Any state change starts a fresh request, so the watchdog restarts there.
    assign wd_load = (state_d != state_q);

    ss2_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_i    (wd_load),
        .en_i      (busy_q),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        gap_d      = gap_q;
        idx_d      = idx_q;
        entry_d    = entry_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        dat_d      = dat_q;
        ptr_d      = ptr_q;
        words_d    = words_q;
        mode_d     = mode_q;
        error_d    = error_q;
        err_code_d = err_code_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_QUERY;
                    mode_d     = restore;
                    ptr_d      = base_addr;
                    words_d    = '0;
                    idx_d      = '0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            S_QUERY: begin
                if (ss.ss_ack[idx_q]) begin
                    hdr_d   = ss.ss_data_in[idx_q];
                    cnt_d   = hdr_d.count;
                    state_d = S_GAP;
                    ret_d   = S_HDR;
                    gap_d   = '0;
                end else if (wd_expired) begin
                    // No answer: the slot is empty, skip it without a header.
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end
            end
            S_HDR: begin
                if (mem.mem_ack) begin
                    ptr_d   = ptr_q + MEMAW'(1);
                    words_d = words_q + MEMAW'(1);
                    entry_d = '0;
                    if (mode_q && (mem.mem_rdata != hdr_q)) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_HDR;
                    end else if (cnt_q == '0) begin
                        state_d = S_NEXT;
                    end else begin
                        // Restore must fetch the word before it can be written to the device.
                        state_d = mode_q ? S_MEM : S_DEV;
                    end
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_MEM_TMO;
                end
            end
            S_DEV: begin
                if (ss.ss_ack[idx_q]) begin
                    if (!mode_q) begin
                        dat_d = ss.ss_data_in[idx_q];
                    end
                    state_d = S_GAP;
                    ret_d   = mode_q ? S_NEXTENT : S_MEM;
                    gap_d   = '0;
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_DEV_TMO;
                end
            end
            S_MEM: begin
                if (mem.mem_ack) begin
                    ptr_d   = ptr_q + MEMAW'(1);
                    words_d = words_q + MEMAW'(1);
                    if (mode_q) begin
                        dat_d   = mem.mem_rdata;
                        state_d = S_DEV;
                    end else begin
                        state_d = S_NEXTENT;
                    end
                end else if (wd_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_MEM_TMO;
                end
            end
            S_NEXTENT: begin
                entry_d = entry_q + 32'd1;
                if (entry_q == cnt_q - 32'd1) begin
                    state_d = S_NEXT;
                end else begin
                    state_d = mode_q ? S_MEM : S_DEV;
                end
            end
            S_NEXT: begin
                idx_d = idx_q + IW'(1);
                state_d = (idx_q == IW'(COUNT - 1)) ? S_DONE : S_QUERY;
            end
            S_GAP: begin
                // Device acks are ignored here.
                if (gap_q == 2'(GAP_CYCLES - 1)) begin
                    state_d = ret_q;
                end else begin
                    gap_d = gap_q + 2'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the next state so every port comes straight from a flop.
        busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        done_d = (state_d == S_DONE);
        if (state_d == S_ERR) begin
            error_d = 1'b1;
        end

        ss_query_d  = (state_d == S_QUERY);
        ss_read_d   = (state_d == S_DEV) && !mode_d;
        ss_write_d  = (state_d == S_DEV) && mode_d;
        ss_select_d = (ss_query_d || ss_read_d || ss_write_d) ? (COUNT'(1) << idx_d) : '0;
        ss_addr_d   = (ss_read_d || ss_write_d) ? entry_d[23:0] : '0;
        ss_data_d   = ss_write_d ? dat_d : '0;

        mem_req_d   = (state_d inside {S_HDR, S_MEM});
        mem_we_d    = mem_req_d && !mode_d;
        mem_wdata_d = !mem_we_d ? '0 : ((state_d == S_HDR) ? hdr_d : dat_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ret_q       <= S_IDLE;
            gap_q       <= '0;
            idx_q       <= '0;
            entry_q     <= '0;
            cnt_q       <= '0;
            hdr_q       <= '0;
            dat_q       <= '0;
            ptr_q       <= '0;
            words_q     <= '0;
            mode_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            ss_data_q   <= '0;
            ss_addr_q   <= '0;
            ss_select_q <= '0;
            ss_write_q  <= 1'b0;
            ss_read_q   <= 1'b0;
            ss_query_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            entry_q     <= entry_d;
            cnt_q       <= cnt_d;
            hdr_q       <= hdr_d;
            dat_q       <= dat_d;
            ptr_q       <= ptr_d;
            words_q     <= words_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            ss_data_q   <= ss_data_d;
            ss_addr_q   <= ss_addr_d;
            ss_select_q <= ss_select_d;
            ss_write_q  <= ss_write_d;
            ss_read_q   <= ss_read_d;
            ss_query_q  <= ss_query_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_req_q   <= mem_req_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign words         = words_q;
    assign ss.ss_data    = ss_data_q;
    assign ss.ss_addr    = ss_addr_q;
    assign ss.ss_select  = ss_select_q;
    assign ss.ss_write   = ss_write_q;
    assign ss.ss_read    = ss_read_q;
    assign ss.ss_query   = ss_query_q;
    assign mem.mem_addr  = ptr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_req   = mem_req_q;

endmodule

// File: doc/ss2_master.md
Name: ss2_master

Overview:
- Initiator side of the save-state device bus. Devices respond on it through the query/read/write/ack handshake.
- On a start pulse, walks device indices 0..COUNT-1 in order:
  - queries each device for its entry count and width;
  - streams every entry between the device and a 64-bit word-addressed buffer memory: save copies device to memory, restore copies memory to device.
- Sits between the core's save-state menu logic and the DDR/SDRAM bridge.

Parameters:
- COUNT, 8, number of device select lines / response slots.
- TIMEOUT, 255, cycles to wait for ss_ack before giving up on one bus transaction.
- MEMAW, 24, buffer memory word-address width.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse begins an operation; ignored while busy
- restore  in  1  sampled at start: 0=save, 1=restore
- base_addr  in  MEMAW  first buffer word, sampled at start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky until next start
- err_code  out  2  0 none, 1 device data timeout, 2 header mismatch, 3 memory timeout
- words  out  MEMAW  buffer words consumed so far; final value valid at done
- ss_data  out  64  write data to device
- ss_addr  out  24  device entry index
- ss_select  out  COUNT  one-hot device select
- ss_write, ss_read, ss_query  out  1 each  bus strobes
- ss_data_in  in  64 x COUNT  per-device response data
- ss_ack  in  COUNT  per-device acknowledge
- mem_addr  out  MEMAW  buffer word address
- mem_wdata  out  64  buffer write data
- mem_we  out  1  1=write, 0=read
- mem_req  out  1  held high until mem_ack
- mem_ack  in  1  one-cycle completion
- mem_rdata  in  64  valid with mem_ack on reads

Behaviour:
- Reset values: every output 0.
- Everything is registered. Reset mid-operation drops all strobes the same cycle and returns to IDLE; there is no resume.
- Bus rule:
  - At most one strobe high, with exactly one ss_select bit.
  - The strobe is held until ss_ack[idx] is seen. It is dropped on the next edge.
  - Then exactly one GAP cycle follows, during which ack is ignored, so the device's stale re-ack clears.
  - A device may therefore execute the final access twice. This is harmless: the second access uses the same address and data.
- Watchdog: counts cycles while a strobe or mem_req is pending and resets on every new request. It expires at TIMEOUT.
- States and transitions:
  - IDLE: start -> QUERY. Clears error, words, idx=0, and sets the memory pointer to base_addr.
  - QUERY: ss_query with ss_select[idx].
    - On ack, capture hdr = ss_data_in[idx]; count = hdr[31:0], width = hdr[33:32], tag = hdr[63:56]. Go to HDR.
    - On watchdog expiry, treat the device as absent: count=0, no header, go to NEXT.
  - HDR (a memory transaction at the pointer; the pointer increments on mem_ack):
    - Save: write hdr.
    - Restore: read, and compare mem_rdata with hdr over all 64 bits. Mismatch -> ERR, code 2.
    - If count==0 -> NEXT, else DEV with entry=0.
  - DEV:
    - Save: ss_read at ss_addr=entry, capture ss_data_in[idx] on ack, -> MEM.
    - Restore: ss_write with ss_data = the word fetched in MEM, -> NEXTENT on ack.
    - Watchdog expiry -> ERR, code 1.
  - MEM:
    - Save: write the captured word, -> NEXTENT.
    - Restore: read the word, -> DEV.
    - The pointer increments on each mem_ack.
    - Watchdog expiry -> ERR, code 3.
  - NEXTENT: entry+1. entry==count-1 -> NEXT, else back to DEV (save) or MEM (restore).
  - NEXT: idx+1. idx==COUNT-1 -> DONE, else QUERY.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
  - ERR: error=1, err_code set, busy=0, -> IDLE.
- Every bus transaction is followed by GAP. Memory transactions need no gap.
- Ordering: within one device, restore performs all memory reads before the writes they feed, strictly alternating one word at a time. There is no prefetch.
- Arithmetic: count is 32-bit. Entry indices above 2^24-1 are truncated onto ss_addr. The pointer wraps modulo 2^MEMAW silently.
- words = pointer - base_addr, modulo 2^MEMAW.
- busy is high from the cycle after start until the cycle done or error asserts.

Decomposition:
- Package ss2_pkg:
  - state enum;
  - header field positions: TAG 63:56, WIDTH 33:32, COUNT 31:0;
  - err_code constants;
  - the GAP length constant (1).
- Sub-module ss2_watchdog: a loadable down-counter with expire output, shared by the bus and memory waits.

Test Plan:
- Save, COUNT=2, dev0 count=3 returning 0xA0+addr, dev1 count=1 returning 0x55, base=0x100 -> memory 0x100..0x105:
  - 0x100 = hdr0 = {0x00, 22'b0, 2'b0, 32'd3};
  - 0x101..0x103 = 0xA0, 0xA1, 0xA2;
  - 0x104 = hdr1 = {0x01, 22'b0, 2'b0, 32'd1};
  - 0x105 = 0x55;
  - done pulse, words=6.
- Restore of that image -> dev0 receives writes 0xA0, 0xA1, 0xA2 at addr 0..2 and dev1 receives 0x55. No strobe is ever high in the cycle after an ack. done=1, error=0.
- Restore with the memory header count altered to 4 -> error=1, err_code=2, no ss_write issued to that device.
- dev1 never acks its query -> dev1 is skipped, dev0 data is saved, done=1, words=4.
- dev0 acks the query but never acks read entry 1 -> after TIMEOUT+1 cycles error=1, err_code=1, all strobes 0.
- reset_n low during dev0 DEV -> all outputs 0 asynchronously. After reset_n rises, a new start runs normally from idx 0.
